ifq_fetch: RTL
==============

Name: ifq_fetch

Overview:
- Instruction fetch queue. It is the requesting end of the icache read interface.
- Issues line-aligned fetch requests (PC, read enable, abort) to the icache and captures each returned 128-bit line into a small FIFO.
- Presents one 32-bit instruction per cycle, with its PC, to dispatch.
- Handles branch redirects by flushing the queue and aborting the icache response already in flight.

Parameters:
- W_DATA, 128, icache line width in bits.
- W_ADDR, 32, address width.
- W_INSN, 32, instruction width.
- W_BYTEALIGN, 4, log2 of line size in bytes. A line is 16 bytes, 4 instructions.
- DEPTH, 4, FIFO capacity in lines. Must be a power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- icache_pcout, out, W_ADDR: fetch address. Always line-aligned; low W_BYTEALIGN bits are 0.
- icache_ren, out, 1: icache read request.
- icache_abort, out, 1: kills the icache response returning this cycle.
- icache_dout, in, W_DATA: returned line. Word i occupies bits [32*i+31 : 32*i].
- icache_dout_valid, in, 1: returned line is valid. Arrives exactly one cycle after the matching icache_ren.
- branch_valid, in, 1: redirect request from the branch unit.
- branch_addr, in, W_ADDR: redirect target. Word-aligned.
- dispatch_ren, in, 1: dispatch consumes the head instruction.
- dispatch_insn, out, W_INSN: head instruction.
- dispatch_pc, out, W_ADDR: PC of the head instruction.
- dispatch_pcplus4, out, W_ADDR: dispatch_pc + 4.
- dispatch_empty, out, 1: no instruction available.

Behaviour:
- State:
  - fetch_pc: next line address to request.
  - FIFO of DEPTH entries, each holding a line plus its line address.
  - head, tail, count: pointers and occupancy, count in range 0..DEPTH.
  - offset: 2-bit word index within the head line.
  - ren_r: a request was issued last cycle.
- Reset (asynchronous) values:
  - fetch_pc = RESET_PC with low 4 bits cleared; offset = RESET_PC[3:2].
  - count = 0, head = 0, tail = 0, ren_r = 0.
  - Outputs: icache_ren = 0, icache_abort = 0, dispatch_empty = 1.
  - dispatch_insn, dispatch_pc and dispatch_pcplus4 are don't-care while empty; drive 0.
- Issue (combinational):
  - icache_ren = !branch_valid && (count + ren_r < DEPTH).
  - icache_pcout = fetch_pc.
  - When icache_ren is 1, fetch_pc <= fetch_pc + 16 and ren_r <= 1; otherwise ren_r <= 0.
  - The credit rule counts the in-flight line, so the FIFO never overflows.
- Capture:
  - When icache_dout_valid && !branch_valid: write icache_dout to FIFO[tail], with line address = fetch_pc - 16 as it was at issue time (track it in a register).
  - Then tail++ and count++.
  - The written line is visible to dispatch the next cycle. There is no bypass.
- Dispatch:
  - dispatch_empty = (count == 0).
  - dispatch_insn = FIFO[head].line word[offset].
  - dispatch_pc = FIFO[head].addr + 4*offset.
  - On dispatch_ren && !dispatch_empty: if offset == 3, pop the line (head++, count--) and set offset = 0; otherwise offset++.
  - dispatch_ren while empty is ignored.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Redirect (branch_valid = 1), which has priority over everything:
  - icache_abort = 1 and icache_ren = 0 in the same cycle, so any returning line is dropped.
  - Next state: count = 0, head = tail = 0, ren_r = 0.
  - fetch_pc = branch_addr with low 4 bits cleared; offset = branch_addr[3:2].
  - dispatch_ren in that cycle has no effect.
  - Back-to-back redirects: the last one wins.
- Redirect latency:
  - Branch at cycle t.
  - icache_ren with the new line at t+1.
  - Line captured at t+2.
  - dispatch_empty = 0 at t+3, with dispatch_pc = branch_addr.
- Outside a redirect, icache_abort is 0.
- Wrap-around: FIFO pointers wrap modulo DEPTH; fetch_pc wraps modulo 2^W_ADDR.
- Reset mid-operation: all state clears immediately. Any pending icache response is not captured, because ren_r = 0 and valid is ignored until a new issue.

Test Plan:
- Reset release with RESET_PC = 0 -> icache_ren = 1 and icache_pcout = 0x00 at the first edge, then 0x10, 0x20, 0x30. With no dispatch_ren, icache_ren drops after 4 lines total are issued or in flight; count reaches 4 and stays.
- Dispatch held high, icache returning lines word[i] = pc → dispatch_insn/dispatch_pc follow 0x0, 0x4, 0x8, … and dispatch_pcplus4 = dispatch_pc + 4. Sustained one instruction per cycle, with no gaps once the queue is primed.
- branch_valid with branch_addr = 0x108 while a response returns in the same cycle:
  - That cycle: icache_abort = 1, icache_ren = 0, and the returning line is not written.
  - Next cycle: icache_pcout = 0x100.
  - Two cycles later: dispatch_pc = 0x108, then 0x10C, then 0x110.
- Queue full, with dispatch_ren and icache_dout_valid in the same cycle → count stays at DEPTH, no line is lost or duplicated, and the PC sequence stays contiguous.
- dispatch_ren pulsed while empty → no state change; offset stays 0 and count stays 0.
- reset asserted asynchronously mid-stream with a response in flight → outputs return to reset values immediately. After release, fetch restarts at RESET_PC and the stale response is never dispatched.

Source files
------------

// File: rtl/ifq_fetch.sv
// Instruction fetch queue: issues line-aligned icache reads, buffers returned
// lines in a small FIFO and hands one instruction per cycle to dispatch.
module ifq_fetch #(
  parameter int                W_DATA      = 128,
  parameter int                W_ADDR      = 32,
  parameter int                W_INSN      = 32,
  parameter int                W_BYTEALIGN = 4,
  parameter int                DEPTH       = 4,
  parameter logic [W_ADDR-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [W_ADDR-1:0] icache_pcout,
  output logic              icache_ren,
  output logic              icache_abort,
  input  logic [W_DATA-1:0] icache_dout,
  input  logic              icache_dout_valid,
  input  logic              branch_valid,
  input  logic [W_ADDR-1:0] branch_addr,
  input  logic              dispatch_ren,
  output logic [W_INSN-1:0] dispatch_insn,
  output logic [W_ADDR-1:0] dispatch_pc,
  output logic [W_ADDR-1:0] dispatch_pcplus4,
  output logic              dispatch_empty
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam int                OFF_W      = W_BYTEALIGN - 2;
  localparam int                WORDS      = W_DATA / W_INSN;
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W+1)'(DEPTH);
  localparam logic [W_ADDR-1:0] LINE_BYTES = W_ADDR'(2 ** W_BYTEALIGN);

  function automatic logic [W_ADDR-1:0] line_align(input logic [W_ADDR-1:0] a);
    return {a[W_ADDR-1:W_BYTEALIGN], {W_BYTEALIGN{1'b0}}};
  endfunction

  logic [W_ADDR-1:0] fetch_pc;
  logic [W_ADDR-1:0] inflight_addr;
  logic [W_DATA-1:0] line_mem [DEPTH];
  logic [W_ADDR-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [OFF_W-1:0]  offset;
  logic              ren_r;

  logic              empty;
  logic              push;
  logic              pop_word;
  logic              pop_line;
  logic [CNT_W:0]    credit;
  logic [W_DATA-1:0] head_line;
  logic [W_INSN-1:0] head_insn;
  logic [W_ADDR-1:0] head_pc;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^branch_addr[1:0];

  // Credit includes the line still in flight, so a returning line always has a slot.
  assign credit       = {1'b0, count} + {{CNT_W{1'b0}}, ren_r};
  assign icache_ren   = !reset && !branch_valid && (credit < DEPTH_C);
  assign icache_abort = !reset && branch_valid;
  assign icache_pcout = fetch_pc;

  assign empty          = (count == '0);
  assign dispatch_empty = empty;
  assign push           = icache_dout_valid && ren_r && !branch_valid;
  assign pop_word       = dispatch_ren && !empty && !branch_valid;
  assign pop_line       = pop_word && (offset == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= line_align(RESET_PC);
      offset   <= RESET_PC[W_BYTEALIGN-1:2];
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      ren_r    <= 1'b0;
    end else if (branch_valid) begin
      fetch_pc <= line_align(branch_addr);
      offset   <= branch_addr[W_BYTEALIGN-1:2];
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      ren_r    <= 1'b0;
    end else begin
      ren_r <= icache_ren;
      if (icache_ren) fetch_pc <= fetch_pc + LINE_BYTES;
      if (push)       tail     <= tail + PTR_W'(1);
      if (pop_line)   head     <= head + PTR_W'(1);
      if (pop_word)   offset   <= offset + OFF_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_line);
    end
  end

  // Line storage and the in-flight address carry no reset; occupancy guards them.
  always_ff @(posedge clk) begin
    if (icache_ren) inflight_addr <= fetch_pc;
    if (push) begin
      line_mem[tail] <= icache_dout;
      addr_mem[tail] <= inflight_addr;
    end
  end

  always_comb begin
    head_line = line_mem[head];
    head_insn = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (offset == OFF_W'(i)) head_insn = head_line[i*W_INSN +: W_INSN];
    end
    head_pc          = addr_mem[head] + W_ADDR'({offset, 2'b00});
    dispatch_insn    = empty ? '0 : head_insn;
    dispatch_pc      = empty ? '0 : head_pc;
    dispatch_pcplus4 = empty ? '0 : head_pc + W_ADDR'(4);
  end

endmodule
